// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO sitting directly in front of the UART transmitter. Producers push
// bursts of bytes. The read side is first-word-fall-through: the head byte is
// presented on o_tx_data whenever o_tx_valid is high, and it is consumed on any
// edge where i_tx_rdy is also high.
//
// Ports:
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous, active-high reset (queue emptied, flags cleared)
//   i_wr_data      byte to enqueue
//   i_wr_valid     push request for i_wr_data
//   o_wr_rdy       FIFO can accept a push this cycle (not full)
//   o_tx_data      head-of-queue byte, meaningful while o_tx_valid
//   o_tx_valid     head entry present (not empty)
//   i_tx_rdy       transmitter takes the head byte this cycle
//   o_count        current occupancy, 0..DEPTH
//   o_empty        occupancy == 0
//   o_almost_full  occupancy >= ALMOST_FULL
//   o_overflow     sticky push-while-full flag
//
// Build option:
//   UART_TX_FIFO_OVERFLOW_EN  when defined, o_overflow is a sticky flag set by
//                             any push attempt while full and cleared only by
//                             i_rst. When undefined, o_overflow is tied to 0.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12,
    parameter int PTR_SIZE    = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [7:0]          i_wr_data,
    input  logic                i_wr_valid,
    output logic                o_wr_rdy,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_rdy,
    output logic [PTR_SIZE:0]   o_count,
    output logic                o_empty,
    output logic                o_almost_full,
    output logic                o_overflow
);

    localparam logic [PTR_SIZE:0] AF_LEVEL = (PTR_SIZE + 1)'(ALMOST_FULL);

    logic [7:0]        mem [DEPTH];
    logic [PTR_SIZE:0] wr_ptr;
    logic [PTR_SIZE:0] rd_ptr;
    logic [PTR_SIZE:0] count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_SIZE] != rd_ptr[PTR_SIZE]) &&
                   (wr_ptr[PTR_SIZE-1:0] == rd_ptr[PTR_SIZE-1:0]);
    assign count = wr_ptr - rd_ptr;

    // Flags come from registered pointers only, so a pop on the same edge as a
    // push-while-full does not let the push in; o_wr_rdy rises a cycle later.
    assign push = i_wr_valid && !full;
    assign pop  = i_tx_rdy && !empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; only the pointers define contents.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem[wr_ptr[PTR_SIZE-1:0]] <= i_wr_data;
        end
    end

    assign o_tx_data     = mem[rd_ptr[PTR_SIZE-1:0]];
    assign o_tx_valid    = !empty;
    assign o_empty       = empty;
    assign o_wr_rdy      = !full;
    assign o_count       = count;
    assign o_almost_full = (count >= AF_LEVEL);

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic overflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow <= 1'b0;
        end else if (i_wr_valid && full) begin
            overflow <= 1'b1;
        end
    end

    assign o_overflow = overflow;
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

`ifdef UART_TX_FIFO_OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_rdy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_rdy;
    logic [4:0] count;
    logic       empty;
    logic       almost_full;
    logic       overflow;

    uart_tx_fifo #(.DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr_data     (wr_data),
        .i_wr_valid    (wr_valid),
        .o_wr_rdy      (wr_rdy),
        .o_tx_data     (tx_data),
        .o_tx_valid    (tx_valid),
        .i_tx_rdy      (tx_rdy),
        .o_count       (count),
        .o_empty       (empty),
        .o_almost_full (almost_full),
        .o_overflow    (overflow)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    bit         checking = 1'b0;
    logic [7:0] q[$];
    bit         ovf_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference queue: one transfer per handshake, judged on pre-edge occupancy.
    task automatic model_step();
        int  sz;
        bit  do_pop;
        bit  do_push;
        sz = q.size();
        if (rst) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            do_pop  = tx_rdy && (sz > 0);
            do_push = wr_valid && (sz < DEPTH);
            if (OVF_ON && wr_valid && sz == DEPTH) ovf_m = 1'b1;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(wr_data);
        end
    endtask

    task automatic compare_model();
        int sz;
        sz = q.size();
        chk("m_count", 32'(count), 32'(sz));
        chk("m_empty", 32'(empty), 32'(sz == 0));
        chk("m_tx_valid", 32'(tx_valid), 32'(sz != 0));
        chk("m_wr_rdy", 32'(wr_rdy), 32'(sz != DEPTH));
        chk("m_almost_full", 32'(almost_full), 32'(sz >= AF));
        chk("m_overflow", 32'(overflow), 32'(ovf_m));
        if (sz > 0) chk("m_tx_data", 32'(tx_data), 32'(q[0]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (checking) compare_model();
    endtask

    initial begin
        rst      = 1'b1;
        wr_data  = 8'h00;
        wr_valid = 1'b0;
        tx_rdy   = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        checking = 1'b1;

        // Reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Ready held while empty changes nothing
        tx_rdy = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        tx_rdy = 1'b0;
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_tx_valid", 32'(tx_valid), 32'd0);

        // Single byte, one-cycle latency, single-cycle ready pulse
        wr_data = 8'h55; wr_valid = 1'b1;
        cyc();
        wr_valid = 1'b0;
        chk("one_tx_valid", 32'(tx_valid), 32'd1);
        chk("one_tx_data", 32'(tx_data), 32'h55);
        chk("one_count", 32'(count), 32'd1);
        tx_rdy = 1'b1;
        cyc();
        tx_rdy = 1'b0;
        chk("one_empty", 32'(empty), 32'd1);

        // Fill 0x00..0x0F
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = 8'(i); wr_valid = 1'b1;
            cyc();
            if (i == AF - 2) chk("af_before", 32'(almost_full), 32'd0);
            if (i == AF - 1) chk("af_at12", 32'(almost_full), 32'd1);
        end
        chk("full_wr_rdy", 32'(wr_rdy), 32'd0);
        chk("full_count", 32'(count), 32'd16);
        wr_data = 8'hAA;
        cyc();
        wr_valid = 1'b0;
        chk("refused_count", 32'(count), 32'd16);
        chk("refused_head", 32'(tx_data), 32'h00);
        tx_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(tx_data), 32'(i));
            cyc();
        end
        tx_rdy = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);

        // Fill, then push while full with a same-edge pop: push refused
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = 8'(8'h80 + i); wr_valid = 1'b1;
            cyc();
        end
        wr_data = 8'hEE; tx_rdy = 1'b1;
        cyc();
        wr_valid = 1'b0; tx_rdy = 1'b0;
        chk("fullpop_count", 32'(count), 32'd15);
        chk("fullpop_wr_rdy", 32'(wr_rdy), 32'd1);

        // Alternate pop/push for 40 bytes, pointers wrap
        for (int k = 0; k < 40; k++) begin
            tx_rdy = 1'b1; wr_valid = 1'b0;
            cyc();
            tx_rdy = 1'b0; wr_valid = 1'b1; wr_data = 8'(k);
            cyc();
        end
        wr_valid = 1'b0;
        chk("wrap_head", 32'(tx_data), 32'h19);
        chk("wrap_count", 32'(count), 32'd15);

        // Drain to 5, then simultaneous push and pop
        tx_rdy = 1'b1;
        for (int i = 0; i < 20 && q.size() > 5; i++) cyc();
        tx_rdy = 1'b0;
        chk("five_count", 32'(count), 32'd5);
        wr_data = 8'h77; wr_valid = 1'b1; tx_rdy = 1'b1;
        cyc();
        wr_valid = 1'b0; tx_rdy = 1'b0;
        chk("pushpop_count", 32'(count), 32'd5);
        chk("pushpop_head", 32'(tx_data), 32'h24);
        tx_rdy = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
        tx_rdy = 1'b0;

        // Reset mid-drain
        for (int i = 1; i <= 3; i++) begin
            wr_data = 8'(i); wr_valid = 1'b1;
            cyc();
        end
        wr_valid = 1'b0; tx_rdy = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; tx_rdy = 1'b0;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        wr_data = 8'h3C; wr_valid = 1'b1;
        cyc();
        wr_valid = 1'b0;
        chk("midrst_first", 32'(tx_data), 32'h3C);
        tx_rdy = 1'b1;
        cyc();
        tx_rdy = 1'b0;

        // Overflow flag
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = 8'(8'hC0 + i); wr_valid = 1'b1;
            cyc();
        end
        wr_data = 8'hAA;
        cyc();
        wr_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 32'(OVF_ON));
        chk("ovf_count", 32'(count), 32'd16);
        tx_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) cyc();
        tx_rdy = 1'b0;
        chk("ovf_sticky", 32'(overflow), 32'(OVF_ON));
        chk("ovf_drained", 32'(empty), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
